// File: rtl/hci_source_job_scheduler.sv
// Job scheduler for one TCDM source streamer: buffers job descriptors in a FIFO,
// issues them one at a time with a start pulse, counts completions and watches for hangs.
module hci_source_job_scheduler #(
    parameter int unsigned JOB_WIDTH      = 128,
    parameter int unsigned QUEUE_DEPTH    = 4,
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               clear_i,
    input  logic                               enable_i,
    input  logic                               job_valid_i,
    output logic                               job_ready_o,
    input  logic [JOB_WIDTH-1:0]               job_data_i,
    output logic                               streamer_req_start_o,
    output logic [JOB_WIDTH-1:0]               streamer_job_o,
    input  logic                               streamer_ready_start_i,
    input  logic                               streamer_done_i,
    output logic                               busy_o,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_level_o,
    output logic [CNT_WIDTH-1:0]               jobs_done_o,
    output logic                               evt_done_o,
    output logic                               error_o
);

    localparam int unsigned LVL_W = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit          WD_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT_CYCLES);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RUN
    } state_e;

    state_e                 state_q, state_d;
    logic [JOB_WIDTH-1:0]   job_q, job_d;
    logic [CNT_WIDTH-1:0]   done_cnt_q, done_cnt_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic                   err_q, err_d;
    logic                   req_start;
    logic                   evt_done;

    logic [JOB_WIDTH-1:0]   mem_q [QUEUE_DEPTH];
    logic [PTR_W-1:0]       rd_ptr_q, wr_ptr_q;
    logic [LVL_W-1:0]       level_q;
    logic                   push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign job_ready_o = enable_i & (level_q != LVL_MAX);
    assign push        = job_valid_i & job_ready_o & ~clear_i;
    // The head leaves the queue only at the end of ISSUE, so a new job never bypasses the FIFO.
    assign pop         = enable_i & ~clear_i & (state_q == ISSUE);

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= job_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else if (clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            unique case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        job_d      = job_q;
        done_cnt_d = done_cnt_q;
        wd_d       = wd_q;
        err_d      = err_q;
        req_start  = 1'b0;
        evt_done   = 1'b0;
        if (clear_i) begin
            state_d    = IDLE;
            job_d      = '0;
            done_cnt_d = '0;
            wd_d       = '0;
            err_d      = 1'b0;
        end else if (enable_i) begin
            unique case (state_q)
                IDLE: begin
                    if ((level_q != '0) && streamer_ready_start_i) begin
                        state_d = ISSUE;
                        job_d   = mem_q[rd_ptr_q];
                    end
                end
                ISSUE: begin
                    req_start = 1'b1;
                    state_d   = RUN;
                    wd_d      = '0;
                end
                RUN: begin
                    if (streamer_done_i) begin
                        done_cnt_d = done_cnt_q + CNT_WIDTH'(1);
                        state_d    = IDLE;
                        evt_done   = (level_q == '0);
                    end else if (WD_EN && (wd_q != WD_MAX)) begin
                        // Saturating watchdog; the job keeps running after the error is flagged.
                        wd_d = wd_q + WD_W'(1);
                        if (wd_d == WD_MAX) begin
                            err_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            job_q      <= '0;
            done_cnt_q <= '0;
            wd_q       <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            job_q      <= job_d;
            done_cnt_q <= done_cnt_d;
            wd_q       <= wd_d;
            err_q      <= err_d;
        end
    end

    assign streamer_req_start_o = req_start;
    assign streamer_job_o       = job_q;
    assign evt_done_o           = evt_done;
    assign jobs_done_o          = done_cnt_q;
    assign error_o              = err_q;
    assign queue_level_o        = level_q;
    assign busy_o               = (state_q != IDLE) | (level_q != '0);

endmodule
